// File: rtl/test_port_pkg.sv
// test_port_pkg
// Shared definitions for the test-port responder: the controller state
// encoding and the default data width and buffer depth.
// Optional feature macro used by the top level: TEST_PORT_CNT_EN.
package test_port_pkg;

  // Controller states. The encoding is fixed so that older code comparing
  // against raw two-bit constants keeps working.
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } tp_state_t;

  localparam int TP_DATA_W     = 32;
  localparam int TP_FIFO_DEPTH = 4;

endpackage

// File: rtl/test_port_fifo.sv
// test_port_fifo
// Synchronous FIFO that buffers output-register values for the host.
// The read and write pointers carry one extra wrap bit beyond the address.
// Equal pointers mean empty. Equal addresses with differing wrap bits mean full.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   push, wr_data write request and data (ignored when full)
//   pop           read request (ignored when empty)
//   rd_data       head entry, forced to zero while empty
//   full, empty   occupancy flags
//   count         number of stored entries
module test_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Stale storage is never visible. An empty FIFO always presents zero.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update. A push and a pop may both complete in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The storage array has no reset. Its contents are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/test_port_ctrl.sv
// test_port_ctrl
// Responder for the decoder's OutR and HLT strobes. OutR values are queued
// in a small FIFO and offered to the host over a valid/ready port. HLT
// drains the queue and parks the core in HALTED until the host resumes it.
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   outr_i, data_i          output-register strobe and its value
//   hlt_i                   halt strobe
//   stall_o                 core must hold its current instruction
//   halted_o                core is halted
//   out_valid_o/out_data_o  head of the output queue
//   out_ready_i             host accepts the head value
//   resume_i                host restart pulse (honoured only in HALTED)
//   out_count_o             completed host pops, 16-bit wrapping
//                           (present only when TEST_PORT_CNT_EN is defined)
module test_port_ctrl
  import test_port_pkg::*;
#(
  parameter int DATA_W     = TP_DATA_W,
  parameter int FIFO_DEPTH = TP_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              outr_i,
  input  logic              hlt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              stall_o,
  output logic              halted_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              resume_i
`ifdef TEST_PORT_CNT_EN
  ,
  output logic [15:0]       out_count_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_DRAIN  = DRAIN;
  localparam logic [1:0] ST_HALTED = HALTED;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        full;
  logic        empty;
  logic [AW:0] fifo_count;
  logic        push;
  logic        pop;
  logic        instr_stall;

  // An OutR that meets a full queue stalls the whole instruction.
  // Full is sampled before any same-cycle pop.
  assign instr_stall = outr_i && full;
  assign push        = (state == ST_RUN) && outr_i && !full;
  assign pop         = out_valid_o && out_ready_i;

  assign out_valid_o = !empty;
  assign stall_o     = (state != ST_RUN) || instr_stall;
  assign halted_o    = (state == ST_HALTED);

  test_port_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (data_i),
    .pop     (pop),
    .rd_data (out_data_o),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Next-state logic. A halt sees the occupancy after this cycle's push, so
  // OutR+HLT into an empty queue goes to DRAIN. DRAIN leaves as soon as
  // the queue reaches empty, including the cycle of the last pop.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (hlt_i && !instr_stall)
          next_state = (!empty || push) ? ST_DRAIN : ST_HALTED;
      end
      ST_DRAIN: begin
        if (empty || (pop && (fifo_count == (AW+1)'(1))))
          next_state = ST_HALTED;
      end
      ST_HALTED: begin
        if (resume_i) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

`ifdef TEST_PORT_CNT_EN
  // Count of values the host has taken. It wraps at 16 bits and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_count_o <= 16'h0000;
    else if (pop) out_count_o <= out_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_test_port_ctrl.sv
// tb_test_port_ctrl
// Directed bench for test_port_ctrl. A queue-based model tracks the output
// buffer and the run/drain/halted mode. A negedge process compares every
// output against it, and literal checks pin key cycles.
// Define TEST_PORT_CNT_EN to also exercise out_count_o.
module tb_test_port_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              outr_i = 1'b0;
  logic              hlt_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic              out_ready_i = 1'b0;
  logic              resume_i = 1'b0;
  logic              stall_o;
  logic              halted_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
`ifdef TEST_PORT_CNT_EN
  logic [15:0]       out_count_o;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  test_port_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .outr_i      (outr_i),
    .hlt_i       (hlt_i),
    .data_i      (data_i),
    .stall_o     (stall_o),
    .halted_o    (halted_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .resume_i    (resume_i)
`ifdef TEST_PORT_CNT_EN
    ,
    .out_count_o (out_count_o)
`endif
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: a queue of values and a mode (0 run, 1 drain, 2 halted).
  logic [DATA_W-1:0] mq[$];
  int                mmode = 0;
  logic [15:0]       mcount = 16'h0;
  bit                m_full;
  bit                m_pop;
  bit                m_push;
  int                m_after_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mmode  = 0;
      mcount = 16'h0;
    end else begin
      m_full       = (mq.size() == DEPTH);
      m_pop        = (mq.size() > 0) && out_ready_i;
      m_push       = (mmode == 0) && outr_i && !m_full;
      m_after_push = mq.size() + (m_push ? 1 : 0);
      if (m_pop) begin
        void'(mq.pop_front());
        mcount = mcount + 16'd1;
      end
      if (m_push) mq.push_back(data_i);
      case (mmode)
        0: if (hlt_i && !(outr_i && m_full)) mmode = (m_after_push > 0) ? 1 : 2;
        1: if (mq.size() == 0) mmode = 2;
        2: if (resume_i) mmode = 0;
        default: mmode = 0;
      endcase
    end
  end

  // Compare every output against the model on each falling edge.
  logic [31:0] exp_data;
  always @(negedge clk) begin
    exp_data = 32'h0;
    if (mq.size() > 0) exp_data = mq[0];
    check_output("valid",  32'(out_valid_o), 32'(mq.size() > 0));
    check_output("data",   out_data_o, exp_data);
    check_output("stall",  32'(stall_o),
                 32'((mmode != 0) || (outr_i && (mq.size() == DEPTH))));
    check_output("halted", 32'(halted_o), 32'(mmode == 2));
`ifdef TEST_PORT_CNT_EN
    check_output("count",  32'(out_count_o), 32'(mcount));
`endif
  end

  // Drive one cycle of inputs just after the rising edge, then return at the
  // falling edge so the caller can inspect that cycle's outputs.
  task automatic apply_stimulus(input logic o, input logic h, input logic [31:0] d,
                                input logic rdy, input logic res);
    @(posedge clk);
    #1;
    outr_i      = o;
    hlt_i       = h;
    data_i      = d;
    out_ready_i = rdy;
    resume_i    = res;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_valid",  32'(out_valid_o), 32'h0);
    check_output("reset_data",   out_data_o, 32'h0);
    check_output("reset_stall",  32'(stall_o), 32'h0);
    check_output("reset_halted", 32'(halted_o), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic transfer: no bypass, value visible and popped the next cycle
    apply_stimulus(1, 0, 32'h0000_00A5, 1, 0);
    check_output("basic_no_bypass", 32'(out_valid_o), 32'h0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("basic_valid",  32'(out_valid_o), 32'h1);
    check_output("basic_data",   out_data_o, 32'h0000_00A5);
    check_output("basic_halted", 32'(halted_o), 32'h0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("basic_empty", 32'(out_valid_o), 32'h0);

    // Backpressure: four fit, the fifth stalls until a slot is free
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1, 0, 32'(i), 0, 0);
      check_output("bp_fill_stall", 32'(stall_o), 32'h0);
    end
    apply_stimulus(1, 0, 32'h5, 0, 0);
    check_output("bp_full_stall", 32'(stall_o), 32'h1);
    apply_stimulus(1, 0, 32'h5, 1, 0);
    check_output("bp_full_pop_stall", 32'(stall_o), 32'h1);
    check_output("bp_data1", out_data_o, 32'h1);
    apply_stimulus(1, 0, 32'h5, 1, 0);
    check_output("bp_accept_stall", 32'(stall_o), 32'h0);
    check_output("bp_data2", out_data_o, 32'h2);
    for (int i = 3; i <= 5; i++) begin
      apply_stimulus(0, 0, 0, 1, 0);
      check_output("bp_order", out_data_o, 32'(i));
    end
    apply_stimulus(0, 0, 0, 0, 0);

    // Drain then halt, then resume
    apply_stimulus(1, 0, 32'h10, 0, 0);
    apply_stimulus(1, 0, 32'h11, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0);
    check_output("dh_run_stall", 32'(stall_o), 32'h0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("dh_drain_stall", 32'(stall_o), 32'h1);
    check_output("dh_drain_data0", out_data_o, 32'h10);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("dh_drain_data1", out_data_o, 32'h11);
    check_output("dh_not_halted", 32'(halted_o), 32'h0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("dh_halted", 32'(halted_o), 32'h1);
    check_output("dh_halt_stall", 32'(stall_o), 32'h1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("dh_resumed_stall", 32'(stall_o), 32'h0);
    check_output("dh_resumed_halted", 32'(halted_o), 32'h0);

    // Simultaneous OutR and HLT into an empty queue
    apply_stimulus(1, 1, 32'h77, 0, 0);
    check_output("sim_stall", 32'(stall_o), 32'h0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("sim_data", out_data_o, 32'h77);
    check_output("sim_drain_stall", 32'(stall_o), 32'h1);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("sim_halted", 32'(halted_o), 32'h1);
    // A strobe while halted is ignored
    apply_stimulus(1, 0, 32'h99, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("halted_strobe_ignored", 32'(out_valid_o), 32'h0);

    // Resume in RUN is ignored, and HLT on an empty queue halts directly
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("empty_hlt_halted", 32'(halted_o), 32'h1);
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0);

    // OutR+HLT against a full queue: whole instruction stalls, no halt
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 32'h30 + 32'(i), 0, 0);
    apply_stimulus(1, 1, 32'hEE, 0, 0);
    check_output("full_hlt_stall", 32'(stall_o), 32'h1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("full_hlt_still_run", 32'(stall_o), 32'h0);
    repeat (4) apply_stimulus(0, 0, 0, 1, 0);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 32'h21 + 32'(i), 0, 0);
    apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("rst_pre_stall", 32'(stall_o), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_output("rst_mid_valid",  32'(out_valid_o), 32'h0);
    check_output("rst_mid_halted", 32'(halted_o), 32'h0);
    check_output("rst_mid_stall",  32'(stall_o), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(1, 0, 32'h55, 0, 0);
    check_output("rst_after_run", 32'(stall_o), 32'h0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("rst_after_data", out_data_o, 32'h55);
    apply_stimulus(0, 0, 0, 0, 0);

    // Streaming: one push and one pop per cycle
    for (int i = 0; i < 8; i++) apply_stimulus(1, 0, 32'h100 + 32'(i), 1, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("stream_last", out_data_o, 32'h107);
    apply_stimulus(0, 0, 0, 0, 0);

`ifdef TEST_PORT_CNT_EN
    // Pop counter wrap: bring the count to 0xFFFE, then two more pops
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(1, 0, 32'h1, 1, 0);
    for (int i = 0; i < 32'hFFFE; i++) apply_stimulus(1, 0, 32'(i), 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("cnt_preload", 32'(out_count_o), 32'h0000_FFFE);
    apply_stimulus(1, 0, 32'hAB, 1, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("cnt_wrap", 32'(out_count_o), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
